// File: rtl/y_reg_file.sv
// ============================================================================
// y_reg_file
// ----------------------------------------------------------------------------
// Two-read, one-write register file with a pending-write scoreboard, sitting
// in front of the ALU stage. Port A feeds ALU operand `a`, port B feeds `b`,
// and the ALU result `z` comes back on the write port. The scoreboard holds
// one pend bit per register. It is set when an issued instruction claims the
// register as its destination, and cleared when the result is written back.
// The issue logic uses busyA/busyB to stall on operands that are not yet
// written.
//
// Optional feature macro:
//   RF_BYPASS_EN - write-through forwarding. A read port whose address
//                  matches an active write sees wrData and busy=0 in the
//                  same cycle.
//
// Parameters:
//   SIZE      - data width of each register and of all data ports.
//
// Ports:
//   clk       - clock; all state updates on its rising edge.
//   rst_n     - asynchronous active-low reset; clears data and pend bits.
//   rdAddrA   - read address, port A.
//   rdAddrB   - read address, port B.
//   rdDataA   - contents of register rdAddrA (combinational).
//   rdDataB   - contents of register rdAddrB (combinational).
//   busyA     - pend bit of rdAddrA.
//   busyB     - pend bit of rdAddrB.
//   wrEn      - write strobe.
//   wrAddr    - write address.
//   wrData    - write data.
//   claimEn   - claim strobe; marks claimAddr pending.
//   claimAddr - destination register being claimed.
// ============================================================================
module y_reg_file #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rdAddrA,
  input  logic [4:0]      rdAddrB,
  output logic [SIZE-1:0] rdDataA,
  output logic [SIZE-1:0] rdDataB,
  output logic            busyA,
  output logic            busyB,
  input  logic            wrEn,
  input  logic [4:0]      wrAddr,
  input  logic [SIZE-1:0] wrData,
  input  logic            claimEn,
  input  logic [4:0]      claimAddr
);

  logic [SIZE-1:0] regs_r [32];
  logic [31:0]     pend_r;

  logic            wr_ok_s;
  logic            claim_ok_s;
  logic [SIZE:0]   port_a_s;
  logic [SIZE:0]   port_b_s;

  // Read one port. Returns {busy, data}. Register 0 always reads as zero and
  // not busy, and that check comes last so that it also overrides forwarding.
  function automatic logic [SIZE:0] read_port(input logic [4:0] addr);
    logic [SIZE:0] res;
    res = {pend_r[addr], regs_r[addr]};
`ifdef RF_BYPASS_EN
    if (wrEn && (wrAddr == addr)) begin
      res = {1'b0, wrData};
    end else begin
      res = res;
    end
`endif
    if (addr == 5'd0) begin
      res = '0;
    end else begin
      res = res;
    end
    return res;
  endfunction

  // Qualify write and claim strobes; register 0 is never written or claimed.
  always_comb begin
    wr_ok_s    = wrEn && (wrAddr != 5'd0);
    claim_ok_s = claimEn && (claimAddr != 5'd0);
  end

  // Register storage and scoreboard. A claim is applied after the write so
  // that, on a collision, the newer instruction's claim keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= '0;
      end
      pend_r <= 32'd0;
    end else begin
      if (wr_ok_s) begin
        regs_r[wrAddr] <= wrData;
        pend_r[wrAddr] <= 1'b0;
      end
      if (claim_ok_s) begin
        pend_r[claimAddr] <= 1'b1;
      end
    end
  end

  // Combinational read ports. These are forced to zero while reset is held,
  // so a write presented during reset is never forwarded.
  always_comb begin
    if (!rst_n) begin
      port_a_s = '0;
      port_b_s = '0;
    end else begin
      port_a_s = read_port(rdAddrA);
      port_b_s = read_port(rdAddrB);
    end
  end

  // Drive the output ports from the per-port read results.
  always_comb begin
    rdDataA = port_a_s[SIZE-1:0];
    busyA   = port_a_s[SIZE];
    rdDataB = port_b_s[SIZE-1:0];
    busyB   = port_b_s[SIZE];
  end

endmodule

// File: doc/y_reg_file.md
# y_reg_file

Two-read, one-write register file with a pending-write scoreboard. It sits directly upstream of the ALU stage: read port A drives the ALU `a` operand and read port B drives `b`. The ALU result `z` returns on the write port. The scoreboard tracks destinations claimed by in-flight instructions, so the issue logic can stall while an operand is not yet written back.

## Interface
Parameters:
- SIZE, 32, data width of each register and of all data ports.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- rdAddrA  in  5  read address, port A.
- rdAddrB  in  5  read address, port B.
- rdDataA  out  SIZE  contents of register rdAddrA; feeds ALU `a`.
- rdDataB  out  SIZE  contents of register rdAddrB; feeds ALU `b`.
- busyA  out  1  scoreboard bit of rdAddrA (1 = write pending).
- busyB  out  1  scoreboard bit of rdAddrB.
- wrEn  in  1  write strobe.
- wrAddr  in  5  write address.
- wrData  in  SIZE  write data; ALU `z`.
- claimEn  in  1  marks claimAddr pending (instruction issued with that destination).
- claimAddr  in  5  destination register being claimed.

## Operation
- Storage: 32 registers of SIZE bits, plus pend[31:0].
- Register 0:
  - Reads as 0 at all times.
  - Writes to it are discarded.
  - pend[0] is forced to 0, and a claim of register 0 is ignored.
- Reads are combinational. rdDataX = reg[rdAddrX]; busyX = pend[rdAddrX]. Bypass modifies this, see Configuration.
- Write: on a rising edge with wrEn=1 and wrAddr≠0:
  - reg[wrAddr] ← wrData.
  - pend[wrAddr] ← 0.
- Claim: on a rising edge with claimEn=1 and claimAddr≠0, pend[claimAddr] ← 1.
- Simultaneous write and claim to the same register in one edge:
  - The data is written.
  - The claim wins, so pend stays/becomes 1, because the claim belongs to a newer instruction.
- Simultaneous write and claim to different registers: both take effect independently.
- A claim on an already pending register leaves it pending, with no error.
- A write to a register that is not pending still writes data; pend stays 0.
- Both read ports may address the same register, including the one being written.

## Timing
- Reset (rst_n=0):
  - Clears all registers and all pend bits immediately, without waiting for clk.
  - rdDataA/B = 0 and busyA/B = 0 within the same delta; this holds for the whole reset duration.
  - A write or claim presented during reset is lost.
- Deassertion of reset is sampled at the next rising edge; the first write or claim can take effect there.
- Read latency: 0 cycles (combinational from address).
- Write-to-read latency: 1 edge without bypass; 0 with bypass.
- Claim-to-busy latency: busy rises after the claiming edge. It never rises combinationally in the claim cycle.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding on each read port X independently.
  - Condition: wrEn=1, wrAddr=rdAddrX, and rdAddrX≠0.
  - Then rdDataX = wrData and busyX = 0 in that same cycle, even when pend is set or claimEn targets the same address.
  - Register 0 still reads 0.
- RF_BYPASS_EN undefined:
  - rdDataX shows the pre-edge register contents until the write edge.
  - busyX equals the stored pend bit.

## Test plan
- Reset: load reg5=0x1234 and claim reg7, then pulse rst_n low mid-cycle → rdDataA (addr 5)=0 and busyB (addr 7)=0 before the next clk edge.
- Write/read and r0:
  - Write 0xDEADBEEF to reg3 → rdDataA=0xDEADBEEF after the edge.
  - Write 0xFFFFFFFF to reg0 → rdDataB (addr 0)=0.
  - Claim reg0 → busy on addr 0 stays 0.
- Scoreboard:
  - Claim reg9 → busyA=1 after the edge.
  - Write reg9=0x5 → busyA=0 and rdDataA=5 after the edge.
- Collision: same edge writes reg4=0xA and claims reg4 → rdDataA=0xA and busyA=1. Next edge writes reg4=0xB without a claim → busyA=0.
- Bypass:
  - Build with RF_BYPASS_EN; reg6 pending, present wrEn=1, wrAddr=6, wrData=0x77, rdAddrA=rdAddrB=6 → both ports read 0x77 and busy=0 before the edge.
  - Build without it → old value and busy=1 until the edge.
- Dual port: rdAddrA=1 and rdAddrB=2 holding 0x10 and 0x20 → both outputs correct in the same cycle, with no cross-talk while writing reg3.
